sum_accumulator: RTL and testbench
==================================

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter N, default 4, SHALL set the adder operand width; the sum input is N+1 bits.
REQ-002 Parameter FRAME, default 8, SHALL set the samples per frame; legal range 2..256, power of two not required.
REQ-003 Derived constant ACC_W SHALL equal N+1+$clog2(FRAME), the accumulator and result width.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-low reset; 0 = in reset.
REQ-007 clear  input  1  synchronous frame abort, active-high.
REQ-008 in_valid  input  1  the upstream adder sum is valid this cycle.
REQ-009 in_ready  output  1  the block accepts a sum this cycle.
REQ-010 sum  input  N+1  unsigned adder result (in1+in2).
REQ-011 out_valid  output  1  frame result is held on acc_out/max_out.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 acc_out  output  ACC_W  unsigned total of FRAME accepted sums.
REQ-014 max_out  output  N+1  largest sum accepted in the frame.

Function
REQ-015 The FSM SHALL have exactly two states: ACCUM and HOLD.
REQ-016 in_ready SHALL be 1 in ACCUM and 0 in HOLD, with no combinational path from in_valid.
REQ-017 A sample SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-018 On accept, acc SHALL become acc+sum (zero-extended), max SHALL become max(max,sum), and cnt SHALL increment.
REQ-019 On accepting sample number FRAME, the FSM SHALL enter HOLD and cnt SHALL return to 0.
REQ-020 out_valid SHALL be asserted in the cycle after the final sample is accepted (latency 1), and acc_out/max_out SHALL include that final sample.
REQ-021 out_valid SHALL equal (state==HOLD), and acc_out/max_out SHALL be stable while out_valid=1.
REQ-022 In HOLD with out_ready=1, the edge SHALL complete the transfer: state returns to ACCUM, acc and max are cleared to 0, and out_valid drops next cycle.
REQ-023 out_valid, once asserted, SHALL NOT drop without out_ready=1 or clear=1.
REQ-024 The accumulator SHALL never overflow: FRAME maximum sums (2^(N+1)-2 each) fit in ACC_W bits by construction, and no saturation logic is present.
REQ-025 clear=1 SHALL take priority over all other events: acc, max and cnt go to 0, the state goes to ACCUM, and any held result is discarded without counting as a transfer.
REQ-026 A sample presented with clear=1 SHALL NOT be accepted, even though in_ready=1.
REQ-027 acc_out and max_out SHALL drive the live accumulator and max registers at all times; they are meaningful only while out_valid=1.
REQ-028 Sum values with in_valid=0 SHALL be ignored, including X.

Reset
REQ-029 With rst=0, asynchronously: state=ACCUM, acc=0, max=0, cnt=0, out_valid=0, in_ready=1 (in_ready follows state).
REQ-030 Reset asserted mid-frame or in HOLD SHALL discard all partial or held results, and there SHALL be no output activity until a new full frame completes.
REQ-031 After release of reset, the first edge with in_valid=1 SHALL accept a sample.

Verification
REQ-032 N=4, FRAME=8, in_valid held high with sum=30 for 8 cycles -> out_valid=1 on the next cycle, acc_out=240, max_out=30, and in_ready=0 until out_ready.
REQ-033 Sums 1,2,...,8 with out_ready held 0 for 5 cycles -> acc_out=36 and max_out=8 stay stable, out_valid stays 1, and no further samples are accepted.
REQ-034 Bubbly in_valid (every other cycle) over 8 samples of 5 -> acc_out=40, and idle cycles are not counted.
REQ-035 Assert clear after 3 samples of 10, then feed 8 samples of 2 -> acc_out=16 and max_out=2, with no result from the aborted frame.
REQ-036 clear and out_ready both 1 in HOLD -> returns to ACCUM with acc=0; next frame of 8 samples of 1 gives acc_out=8.
REQ-037 Drive rst=0 asynchronously mid-frame (between edges) -> outputs reach reset values immediately, and the following full frame is reported correctly.

Source files
------------

// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the upstream adder, the frame accumulator and the
// downstream result consumer.
interface sum_accumulator_if #(
  parameter int N     = 4,
  parameter int FRAME = 8
);
  localparam int ACC_W = N + 1 + $clog2(FRAME);

  logic             in_valid;
  logic             in_ready;
  logic [N:0]       sum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic [N:0]       max_out;

  // master: the side that supplies sums and consumes frame results
  modport master (
    output in_valid, sum, out_ready,
    input  in_ready, out_valid, acc_out, max_out
  );

  modport slave (
    input  in_valid, sum, out_ready,
    output in_ready, out_valid, acc_out, max_out
  );
endinterface

// File: rtl/sum_accumulator.sv
// Frame accumulator: totals FRAME adder sums, tracks the largest one, and holds
// the frame result until the downstream side takes it.
//
// state | meaning
// ACCUM | accepting sums, acc/max/cnt track the current partial frame
// HOLD  | frame complete, result held on acc_out/max_out until out_ready
module sum_accumulator #(
  parameter int N     = 4,
  parameter int FRAME = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  sum_accumulator_if.slave bus
);
  localparam int ACC_W = N + 1 + $clog2(FRAME);
  localparam int CNT_W = $clog2(FRAME);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [N:0]       max_q;
  logic [CNT_W-1:0] cnt;
  logic             in_ready_q;
  logic             out_valid_q;

  // Handshake flags are registered copies of the state so in_ready has no
  // path from in_valid and out_valid is glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ACCUM;
      acc         <= '0;
      max_q       <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      state       <= ACCUM;
      acc         <= '0;
      max_q       <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.in_valid) begin
            acc <= acc + ACC_W'(bus.sum);
            if (bus.sum > max_q) begin
              max_q <= bus.sum;
            end
            if (cnt == LAST) begin
              cnt         <= '0;
              state       <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= ACCUM;
            acc         <= '0;
            max_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= ACCUM;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc;
  assign bus.max_out   = max_q;
endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: directed frame scenarios with literal results plus
// randomized traffic checked every cycle against a sample-queue model.
module tb_sum_accumulator;
  localparam int N     = 4;
  localparam int FRAME = 8;

  logic clk = 1'b0;
  logic rst;
  logic clear;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  sum_accumulator_if #(.N(N), .FRAME(FRAME)) bus ();

  sum_accumulator #(.N(N), .FRAME(FRAME)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: the frame is just the list of accepted samples; the result is held
  // once the list reaches FRAME entries.
  int mq[$];
  bit mhold;

  always @(posedge clk or negedge rst) begin
    if (!rst || clear) begin
      mq.delete();
      mhold = 1'b0;
    end else if (mhold) begin
      if (bus.out_ready) begin
        mq.delete();
        mhold = 1'b0;
      end
    end else if (bus.in_valid) begin
      mq.push_back(int'(bus.sum));
      if (mq.size() == FRAME) mhold = 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int ea;
    int em;
    if (rst && chk_en) begin
      ea = 0;
      em = 0;
      foreach (mq[i]) begin
        ea += mq[i];
        if (mq[i] > em) em = mq[i];
      end
      chk("model in_ready", int'(bus.in_ready), int'(!mhold));
      chk("model out_valid", int'(bus.out_valid), int'(mhold));
      if (mhold) begin
        chk("model acc_out", int'(bus.acc_out), ea);
        chk("model max_out", int'(bus.max_out), em);
      end
    end
  end

  task automatic feed(input int v);
    bus.in_valid = 1'b1;
    bus.sum      = (N+1)'(v);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.sum      = 'x;
  endtask

  task automatic transfer();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("after transfer out_valid", int'(bus.out_valid), 0);
    chk("after transfer in_ready", int'(bus.in_ready), 1);
  endtask

  task automatic check_result(input string tag, input int acc, input int mx);
    chk({tag, " out_valid"}, int'(bus.out_valid), 1);
    chk({tag, " in_ready"}, int'(bus.in_ready), 0);
    chk({tag, " acc_out"}, int'(bus.acc_out), acc);
    chk({tag, " max_out"}, int'(bus.max_out), mx);
  endtask

  initial begin
    rst           = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.sum       = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset in_ready", int'(bus.in_ready), 1);
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset acc_out", int'(bus.acc_out), 0);
    chk("reset max_out", int'(bus.max_out), 0);
    rst    = 1'b1;
    chk_en = 1'b1;

    // Eight sums of 30, then sums offered during HOLD must be refused.
    for (int i = 0; i < FRAME; i++) feed(30);
    check_result("full30", 240, 30);
    bus.in_valid = 1'b1;
    bus.sum      = 5'd7;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    check_result("full30 held", 240, 30);
    transfer();
    chk("full30 cleared acc", int'(bus.acc_out), 0);

    // Ramp 1..8, result held through 5 cycles of out_ready=0.
    for (int i = 1; i <= FRAME; i++) feed(i);
    bus.in_valid = 1'b1;
    bus.sum      = 5'd15;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_result("ramp held", 36, 8);
    end
    bus.in_valid = 1'b0;
    transfer();

    // Bubbly in_valid with X on sum during idle cycles.
    for (int i = 0; i < FRAME; i++) begin
      feed(5);
      if (i < FRAME - 1) begin
        chk("bubble out_valid", int'(bus.out_valid), 0);
        @(negedge clk);
      end
    end
    check_result("bubble", 40, 5);
    transfer();

    // Abort after 3 samples; a sample offered alongside clear is dropped.
    for (int i = 0; i < 3; i++) feed(10);
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.sum      = 5'd20;
    @(negedge clk);
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort acc_out", int'(bus.acc_out), 0);
    chk("abort max_out", int'(bus.max_out), 0);
    for (int i = 0; i < FRAME; i++) begin
      chk("abort no result", int'(bus.out_valid), 0);
      feed(2);
    end
    check_result("after abort", 16, 2);
    transfer();

    // clear together with out_ready while holding.
    for (int i = 0; i < FRAME; i++) feed(3);
    check_result("pre clear", 24, 3);
    clear         = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    clear         = 1'b0;
    bus.out_ready = 1'b0;
    chk("clear hold out_valid", int'(bus.out_valid), 0);
    chk("clear hold acc_out", int'(bus.acc_out), 0);
    for (int i = 0; i < FRAME; i++) feed(1);
    check_result("after clear", 8, 1);
    transfer();

    // Asynchronous reset between edges, mid-frame.
    for (int i = 0; i < 4; i++) feed(9);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async rst out_valid", int'(bus.out_valid), 0);
    chk("async rst in_ready", int'(bus.in_ready), 1);
    chk("async rst acc_out", int'(bus.acc_out), 0);
    chk("async rst max_out", int'(bus.max_out), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      chk("post rst no result", int'(bus.out_valid), 0);
      feed(7);
    end
    check_result("post rst", 56, 7);
    transfer();

    // Random traffic; the per-cycle model compare does the checking.
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.sum       = (N+1)'($urandom_range(0, 31));
      bus.out_ready = ($urandom_range(0, 9) < 4);
      clear         = ($urandom_range(0, 99) < 3);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    clear         = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
